memaccess: RTL and testbench
============================

MEMACCESS -- requirements
Module: memaccess

Interface
REQ-001 The block SHALL have parameter TMO_CYCLES, default 255, meaning the maximum wait in cycles for complete_data per access phase (used only with the timeout feature).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port mem_start, input, 1, one-cycle strobe from execute/controller requesting an access.
REQ-005 The block SHALL have port mem_op, input, 2, access type: 00 LD/LDR, 01 LDI, 10 ST/STR, 11 STI.
REQ-006 The block SHALL have port M_Addr, input, 16, effective address from execute.
REQ-007 The block SHALL have port M_Data, input, 16, store data from execute.
REQ-008 The block SHALL have port Data_dout, input, 16, data memory read data.
REQ-009 The block SHALL have port complete_data, input, 1, data memory completion for the current phase.
REQ-010 The block SHALL have port Data_addr, output, 16, data memory address.
REQ-011 The block SHALL have port Data_din, output, 16, data memory write data.
REQ-012 The block SHALL have port Data_rd, output, 1, 1 = read and 0 = write, meaningful only while Data_req = 1.
REQ-013 The block SHALL have port Data_req, output, 1, access request held until complete_data.
REQ-014 The block SHALL have port memout, output, 16, load result for writeback.
REQ-015 The block SHALL have port mem_done, output, 1, one-cycle completion pulse.
REQ-016 The block SHALL have port mem_err, output, 1, one-cycle timeout-abort pulse.
REQ-017 The block SHALL have port busy, output, 1, high whenever state != IDLE.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, IND, RD and WR.
REQ-019 In IDLE, mem_start=1 SHALL latch mem_op, M_Addr and M_Data, then go to RD for op 00, IND for op 01/11, and WR for op 10.
REQ-020 mem_start while busy=1 SHALL be ignored: no latch and no state change.
REQ-021 IND SHALL drive Data_req=1, Data_rd=1, Data_addr=latched address; on complete_data=1, ptr<=Data_dout, then go to RD (LDI) or WR (STI).
REQ-022 RD SHALL drive Data_req=1, Data_rd=1, Data_addr=ptr for LDI or the latched address otherwise; on complete_data=1, memout<=Data_dout, mem_done<=1, state->IDLE.
REQ-023 WR SHALL drive Data_req=1, Data_rd=0, Data_din=latched M_Data, Data_addr=ptr for STI or the latched address otherwise; on complete_data=1, mem_done<=1, state->IDLE.
REQ-024 In IDLE, outputs SHALL be Data_req=0, Data_rd=0, Data_addr=0, Data_din=0; Data_din SHALL be 0 in every state except WR.
REQ-025 complete_data in IDLE SHALL be ignored.
REQ-026 Each phase SHALL last ≥1 cycle; complete_data is sampled on the first and every later edge in the phase.
REQ-027 Minimum latency SHALL be: mem_start at edge N -> mem_done high after edge N+2 for LD/ST, and after edge N+3 for LDI/STI.
REQ-028 mem_done and mem_err SHALL be registered and high for exactly one cycle.
REQ-029 memout SHALL hold its value until the next load completes and SHALL be unchanged by stores.
REQ-030 mem_start SHALL be accepted in the same cycle mem_done is high, since the state is then IDLE.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, memout=0, ptr=0, latched regs=0, mem_done=0, mem_err=0, and timeout counter=0.
REQ-032 Reset mid-access SHALL abandon the access with no mem_done pulse; Data_req SHALL drop asynchronously.

Configuration
REQ-033 With MEMACCESS_TIMEOUT_EN defined, a counter SHALL clear on each phase entry and increment each cycle Data_req=1 without complete_data.
REQ-034 With MEMACCESS_TIMEOUT_EN defined, reaching TMO_CYCLES SHALL force IDLE, set memout=0 and pulse mem_err, with no mem_done.
REQ-035 Without MEMACCESS_TIMEOUT_EN, the block SHALL wait indefinitely, mem_err SHALL be tied 0, and no counter SHALL exist.

Verification
REQ-036 Scenario LD: op=00, M_Addr=0x3000, memory completes in 1 cycle returning 0xBEEF -> Data_addr=0x3000, Data_rd=1, memout=0xBEEF, one mem_done pulse at N+2.
REQ-037 Scenario STI: op=11, M_Addr=0x3010, Data_dout=0x4000 on IND, M_Data=0x1234 -> IND read at 0x3010, then write at 0x4000 with Data_din=0x1234, Data_rd=0, memout unchanged.
REQ-038 Scenario LDI with stalls: complete_data delayed 3 cycles per phase -> Data_req held steady, busy=1 throughout, mem_done exactly once after the second completion.
REQ-039 Scenario busy-start: mem_start pulsed during an RD phase with a different address -> ignored, original access completes unchanged.
REQ-040 Scenario reset mid-WR: rst asserted while Data_req=1 -> Data_req=0 immediately, no mem_done, next LD completes normally.
REQ-041 Scenario timeout (macro defined, TMO_CYCLES=4): complete_data never asserted -> mem_err pulse after 4 request cycles, state IDLE, memout=0.

Source files
------------

// File: rtl/memaccess.sv
// -----------------------------------------------------------------------------
// memaccess -- memory-access stage sequencer.
//
// Turns one access request from execute into one or two data-memory phases:
//   op 00 LD/LDR : RD  at M_Addr                  -> memout
//   op 01 LDI    : IND at M_Addr, RD at pointer   -> memout
//   op 10 ST/STR : WR  at M_Addr with M_Data
//   op 11 STI    : IND at M_Addr, WR at pointer with M_Data
// Every phase holds Data_req until complete_data is seen on a rising edge.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   mem_start         : one-cycle request strobe (ignored while busy)
//   mem_op            : access type (see table above)
//   M_Addr, M_Data    : effective address / store data, latched on accept
//   Data_dout         : data-memory read data
//   complete_data     : data-memory completion for the current phase
//   Data_addr/din/rd  : data-memory address, write data, 1=read 0=write
//   Data_req          : data-memory request, high in every non-IDLE state
//   memout            : last load result, unchanged by stores
//   mem_done, mem_err : one-cycle completion / timeout-abort pulses
//   busy              : high whenever the sequencer is not IDLE
//
// Configuration
//   MEMACCESS_TIMEOUT_EN : when defined, a phase that waits TMO_CYCLES cycles
//                          without complete_data is aborted with mem_err and
//                          memout cleared. When undefined, the block waits
//                          indefinitely and mem_err is tied low.
// -----------------------------------------------------------------------------
module memaccess #(
    parameter int TMO_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_start,
    input  logic [1:0]  mem_op,
    input  logic [15:0] M_Addr,
    input  logic [15:0] M_Data,
    input  logic [15:0] Data_dout,
    input  logic        complete_data,
    output logic [15:0] Data_addr,
    output logic [15:0] Data_din,
    output logic        Data_rd,
    output logic        Data_req,
    output logic [15:0] memout,
    output logic        mem_done,
    output logic        mem_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IND  = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } state_e;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;
    localparam logic [1:0] OP_STI = 2'b11;

    state_e      state_q;
    logic [1:0]  op_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] ptr_q;
    logic [15:0] memout_q;
    logic        done_q;

`ifdef MEMACCESS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
    logic             tmo_hit;

    // The current cycle is the TMO_CYCLES-th request cycle without completion.
    assign tmo_hit = !complete_data && (tmo_q == TMO_W'(TMO_CYCLES - 1));
`endif

    // Sequencer: state, latched request, pointer, result and pulses.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; a later assignment in the block overrides an
    // earlier one, which the timeout abort relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            ptr_q    <= 16'h0000;
            memout_q <= 16'h0000;
            done_q   <= 1'b0;
`ifdef MEMACCESS_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MEMACCESS_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (mem_start) begin
                        op_q    <= mem_op;
                        addr_q  <= M_Addr;
                        wdata_q <= M_Data;
                        case (mem_op)
                            OP_LD:   state_q <= RD;
                            OP_ST:   state_q <= WR;
                            default: state_q <= IND;
                        endcase
                    end
                end
                IND: begin
                    if (complete_data) begin
                        ptr_q   <= Data_dout;
                        state_q <= (op_q == OP_STI) ? WR : RD;
                    end
                end
                RD: begin
                    if (complete_data) begin
                        memout_q <= Data_dout;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                WR: begin
                    if (complete_data) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef MEMACCESS_TIMEOUT_EN
            // A completion always ends the phase, so the counter restarts at
            // zero for whatever phase (or IDLE) follows.
            if (state_q != IDLE) begin
                if (tmo_hit) begin
                    state_q  <= IDLE;
                    memout_q <= 16'h0000;
                    err_q    <= 1'b1;
                    tmo_q    <= '0;
                end else if (complete_data) begin
                    tmo_q <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
`endif
        end
    end

    // Memory interface decoded from the state register so that an
    // asynchronous reset drops Data_req immediately.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        Data_req  = 1'b0;
        Data_rd   = 1'b0;
        Data_addr = 16'h0000;
        Data_din  = 16'h0000;
        case (state_q)
            IND: begin
                Data_req  = 1'b1;
                Data_rd   = 1'b1;
                Data_addr = addr_q;
            end
            RD: begin
                Data_req  = 1'b1;
                Data_rd   = 1'b1;
                Data_addr = (op_q == OP_LDI) ? ptr_q : addr_q;
            end
            WR: begin
                Data_req  = 1'b1;
                Data_din  = wdata_q;
                Data_addr = (op_q == OP_STI) ? ptr_q : addr_q;
            end
            default: ;
        endcase
    end

    assign memout   = memout_q;
    assign mem_done = done_q;
    assign busy     = (state_q != IDLE);

`ifdef MEMACCESS_TIMEOUT_EN
    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_memaccess.sv
// -----------------------------------------------------------------------------
// tb_memaccess -- self-checking bench for memaccess.
//
// The bench plays the data memory from a full 64K-word array. For every access
// it derives the expected phase list (address, direction, write data) and the
// expected load result directly from the instruction semantics, then steps the
// DUT through each phase with a chosen number of stall cycles.
// -----------------------------------------------------------------------------
module tb_memaccess;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_start;
    logic [1:0]  mem_op;
    logic [15:0] M_Addr;
    logic [15:0] M_Data;
    logic [15:0] Data_dout;
    logic        complete_data;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic        Data_rd;
    logic        Data_req;
    logic [15:0] memout;
    logic        mem_done;
    logic        mem_err;
    logic        busy;

    memaccess #(.TMO_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_start     (mem_start),
        .mem_op        (mem_op),
        .M_Addr        (M_Addr),
        .M_Data        (M_Data),
        .Data_dout     (Data_dout),
        .complete_data (complete_data),
        .Data_addr     (Data_addr),
        .Data_din      (Data_din),
        .Data_rd       (Data_rd),
        .Data_req      (Data_req),
        .memout        (memout),
        .mem_done      (mem_done),
        .mem_err       (mem_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] mem_m [65536];
    logic [15:0] exp_memout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One complete access. stall < 0 picks 0..3 stall cycles per phase at random.
    // b2b issues mem_start in the current (mem_done) cycle instead of waiting
    // an idle cycle. inject pulses a conflicting mem_start during the last phase.
    // Returns with time at the falling edge of the mem_done cycle.
    task automatic run_access(input logic [1:0] op, input logic [15:0] addr,
                              input logic [15:0] wdata, input int stall,
                              input bit b2b, input bit inject);
        int          nph;
        int          st;
        logic [15:0] pa  [2];
        logic        prd [2];
        logic [15:0] ptr;

        // Reference phase list from the instruction semantics.
        ptr = mem_m[addr];
        nph = 1;
        pa[0] = addr; prd[0] = 1'b1;
        pa[1] = ptr;  prd[1] = 1'b1;
        case (op)
            2'b00: nph = 1;
            2'b01: nph = 2;
            2'b10: begin nph = 1; prd[0] = 1'b0; end
            default: begin nph = 2; prd[1] = 1'b0; end
        endcase

        if (!b2b) begin
            @(posedge clk); #1;
            // A stray completion in IDLE, also present at the accepting edge.
            complete_data = 1'($urandom_range(0, 1));
            Data_dout     = 16'($urandom);
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", mem_done, 0);
        end
        mem_start = 1'b1;
        mem_op    = op;
        M_Addr    = addr;
        M_Data    = wdata;
        @(posedge clk); #1;
        mem_start     = 1'b0;
        complete_data = 1'b0;
        mem_op        = 2'($urandom);
        M_Addr        = 16'($urandom);
        M_Data        = 16'($urandom);

        for (int p = 0; p < nph; p++) begin
            st = (stall < 0) ? $urandom_range(0, 3) : stall;
            for (int s = 0; s <= st; s++) begin
                @(negedge clk);
                check("ph_req",  Data_req, 1);
                check("ph_busy", busy, 1);
                check("ph_rd",   Data_rd, prd[p]);
                check("ph_addr", Data_addr, pa[p]);
                check("ph_din",  Data_din, prd[p] ? 16'h0000 : wdata);
                check("ph_done", mem_done, 0);
                check("ph_err",  mem_err, 0);
                if (inject && p == nph - 1 && s == 0) begin
                    mem_start = 1'b1;
                    mem_op    = 2'($urandom);
                    M_Addr    = addr ^ 16'h00F0;
                end
                if (s == st) begin
                    complete_data = 1'b1;
                    Data_dout     = prd[p] ? mem_m[pa[p]] : 16'($urandom);
                end else begin
                    Data_dout     = 16'($urandom);
                end
                @(posedge clk); #1;
                complete_data = 1'b0;
                mem_start     = 1'b0;
            end
            if (!prd[p]) mem_m[pa[p]] = wdata;
            else if (p == nph - 1) exp_memout = mem_m[pa[p]];
        end

        @(negedge clk);
        check("end_done",   mem_done, 1);
        check("end_err",    mem_err, 0);
        check("end_memout", memout, exp_memout);
        check("end_busy",   busy, 0);
        check("end_req",    Data_req, 0);
        check("end_rd",     Data_rd, 0);
        check("end_addr",   Data_addr, 0);
        check("end_din",    Data_din, 0);
    endtask

    initial begin
        rst           = 1'b1;
        mem_start     = 1'b0;
        mem_op        = 2'b00;
        M_Addr        = 16'h0000;
        M_Data        = 16'h0000;
        Data_dout     = 16'h0000;
        complete_data = 1'b0;
        exp_memout    = 16'h0000;
        for (int i = 0; i < 65536; i++) mem_m[i] = 16'($urandom);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   busy, 0);
        check("rst_req",    Data_req, 0);
        check("rst_addr",   Data_addr, 0);
        check("rst_din",    Data_din, 0);
        check("rst_memout", memout, 0);
        check("rst_done",   mem_done, 0);
        check("rst_err",    mem_err, 0);
        rst = 1'b0;

        // LD at 0x3000, single-cycle memory.
        mem_m[16'h3000] = 16'hBEEF;
        run_access(2'b00, 16'h3000, 16'h0000, 0, 1'b0, 1'b0);

        // STI through 0x3010 -> 0x4000, started in the mem_done cycle.
        mem_m[16'h3010] = 16'h4000;
        run_access(2'b11, 16'h3010, 16'h1234, 0, 1'b1, 1'b0);

        // LDI with three stall cycles in each phase.
        run_access(2'b01, 16'h3020, 16'h0000, 3, 1'b0, 1'b0);

        // LD with a conflicting mem_start during the RD phase.
        run_access(2'b00, 16'h2222, 16'h0000, 2, 1'b0, 1'b1);

        // Reset in the middle of a WR phase.
        @(posedge clk); #1;
        mem_start = 1'b1;
        mem_op    = 2'b10;
        M_Addr    = 16'h5000;
        M_Data    = 16'hCAFE;
        @(posedge clk); #1;
        mem_start = 1'b0;
        @(negedge clk);
        check("mwr_req", Data_req, 1);
        check("mwr_rd",  Data_rd, 0);
        #1 rst = 1'b1;
        #1;
        check("mwr_rst_req",    Data_req, 0);
        check("mwr_rst_busy",   busy, 0);
        check("mwr_rst_memout", memout, 0);
        exp_memout = 16'h0000;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mwr_rst_done", mem_done, 0);
        run_access(2'b00, 16'h5000, 16'h0000, -1, 1'b0, 1'b0);

`ifdef MEMACCESS_TIMEOUT_EN
        // LD that never completes: abort after TMO request cycles.
        @(posedge clk); #1;
        mem_start = 1'b1;
        mem_op    = 2'b00;
        M_Addr    = 16'h6000;
        @(posedge clk); #1;
        mem_start = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            check("tmo_req", Data_req, 1);
            check("tmo_err_early", mem_err, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("tmo_err",    mem_err, 1);
        check("tmo_done",   mem_done, 0);
        check("tmo_busy",   busy, 0);
        check("tmo_memout", memout, 0);
        exp_memout = 16'h0000;
        @(posedge clk); #1;
        @(negedge clk);
        check("tmo_err_pulse", mem_err, 0);
`endif

        // Randomized accesses.
        for (int k = 0; k < 40; k++) begin
            run_access(2'($urandom), 16'($urandom), 16'($urandom), -1,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        @(negedge clk);
        check("final_done", mem_done, 0);
        check("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
